// File: rtl/utopia_modport_pkg.sv
// Shared constants, cell byte index type and FSM state encodings for the
// Utopia Level 1 cell relay.
package utopia_modport_pkg;
  localparam int IfWidth   = 8;
  localparam int CellBytes = 53;

  typedef logic [5:0] cell_idx_t;

  localparam cell_idx_t LastIdx = 6'(CellBytes - 1);
  localparam cell_idx_t CellEnd = 6'(CellBytes);

  typedef enum logic {RX_IDLE, RX_CELL} rx_state_t;
  typedef enum logic {TX_IDLE, TX_CELL} tx_state_t;
endpackage

// File: rtl/utopia_modport_cell_buffer.sv
// Two-slot cell store: one byte write port and one byte read port, with circular
// slot pointers and an occupancy count that only changes on whole-cell commit/free.
module utopia_modport_cell_buffer
  import utopia_modport_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  cell_idx_t          widx,
  input  logic [IfWidth-1:0] wdata,
  input  logic               commit,
  input  cell_idx_t          ridx,
  output logic [IfWidth-1:0] rdata,
  input  logic               free,
  output logic [1:0]         occ
);
  logic [IfWidth-1:0] mem [2][CellBytes];
  logic               wp, rp;

  always_ff @(posedge clk)
    if (we) mem[wp][widx] <= wdata;

  assign rdata = mem[rp][ridx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (commit) wp <= ~wp;
      if (free)   rp <= ~rp;
      case ({commit, free})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: rtl/utopia_modport.sv
// ATM cell relay: receive FSM pulls whole cells from the PHY into a two-cell
// buffer, transmit FSM pushes them out with a cell-level handshake.
module utopia_modport
  import utopia_modport_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IfWidth-1:0] rx_data,
  input  logic               rx_soc,
  input  logic               rx_clav,
  output logic               rx_en,
  output logic [IfWidth-1:0] tx_data,
  output logic               tx_soc,
  output logic               tx_en,
  input  logic               tx_clav,
  output logic [15:0]        rx_cells,
  output logic [15:0]        tx_cells,
  output logic [7:0]         err_cnt
);
  rx_state_t          rx_state, rx_state_n;
  tx_state_t          tx_state, tx_state_n;
  cell_idx_t          rx_idx, rx_idx_n, wr_idx;
  cell_idx_t          tx_idx, tx_idx_n, rd_idx;
  logic               rx_en_n, wr_en, commit, rx_err;
  logic               tx_en_n, tx_soc_n, free;
  logic [IfWidth-1:0] tx_data_n, rd_data;
  logic [1:0]         occ;

  utopia_modport_cell_buffer u_buf (
    .clk(clk), .rst_n(rst_n),
    .we(wr_en), .widx(wr_idx), .wdata(rx_data), .commit(commit),
    .ridx(rd_idx), .rdata(rd_data), .free(free), .occ(occ)
  );

  // Occupancy is the registered value, so a slot freed this cycle is not yet usable.
  always_comb begin
    rx_state_n = rx_state;
    rx_idx_n   = rx_idx;
    rx_en_n    = rx_en;
    wr_en      = 1'b0;
    wr_idx     = rx_idx;
    commit     = 1'b0;
    rx_err     = 1'b0;
    case (rx_state)
      RX_IDLE:
        if (rx_clav && occ < 2'd2) begin
          rx_state_n = RX_CELL;
          rx_en_n    = 1'b0;
          rx_idx_n   = '0;
        end
      RX_CELL:
        if (!rx_en) begin
          if (rx_idx == '0 && !rx_soc) begin
            rx_err = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (rx_soc && rx_idx != '0) begin
              // Restart: the partial cell is dropped and this byte becomes byte 0.
              rx_err   = 1'b1;
              wr_idx   = '0;
              rx_idx_n = 6'd1;
            end else if (rx_idx == LastIdx) begin
              commit     = 1'b1;
              rx_en_n    = 1'b1;
              rx_state_n = RX_IDLE;
              rx_idx_n   = '0;
            end else begin
              rx_idx_n = rx_idx + 6'd1;
            end
          end
        end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // tx_idx is the next byte to drive; CellEnd marks the closing idle edge.
  assign rd_idx = (tx_idx == CellEnd) ? '0 : tx_idx;

  always_comb begin
    tx_state_n = tx_state;
    tx_idx_n   = tx_idx;
    tx_en_n    = tx_en;
    tx_soc_n   = 1'b0;
    tx_data_n  = tx_data;
    free       = 1'b0;
    case (tx_state)
      TX_IDLE:
        if (occ != 2'd0 && tx_clav) begin
          tx_state_n = TX_CELL;
          tx_data_n  = rd_data;
          tx_soc_n   = 1'b1;
          tx_en_n    = 1'b0;
          tx_idx_n   = 6'd1;
        end
      TX_CELL:
        if (tx_idx == CellEnd) begin
          tx_state_n = TX_IDLE;
          tx_en_n    = 1'b1;
          tx_data_n  = '0;
          free       = 1'b1;
          tx_idx_n   = '0;
        end else begin
          tx_data_n = rd_data;
          tx_idx_n  = tx_idx + 6'd1;
        end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
      rx_idx   <= '0;
      tx_idx   <= '0;
      rx_en    <= 1'b1;
      tx_en    <= 1'b1;
      tx_soc   <= 1'b0;
      tx_data  <= '0;
      rx_cells <= '0;
      tx_cells <= '0;
      err_cnt  <= '0;
    end else begin
      rx_state <= rx_state_n;
      tx_state <= tx_state_n;
      rx_idx   <= rx_idx_n;
      tx_idx   <= tx_idx_n;
      rx_en    <= rx_en_n;
      tx_en    <= tx_en_n;
      tx_soc   <= tx_soc_n;
      tx_data  <= tx_data_n;
      if (commit) rx_cells <= rx_cells + 16'd1;
      if (free)   tx_cells <= tx_cells + 16'd1;
      if (rx_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_utopia_modport.sv
// Bench for utopia_modport: queue-driven PHY on both sides, expected byte stream
// and counters derived from the cell framing rules.
module tb_utopia_modport;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_soc = 1'b0;
  logic        rx_clav = 1'b0;
  logic        rx_en;
  logic [7:0]  tx_data;
  logic        tx_soc;
  logic        tx_en;
  logic        tx_clav = 1'b0;
  logic [15:0] rx_cells;
  logic [15:0] tx_cells;
  logic [7:0]  err_cnt;

  utopia_modport dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_soc(rx_soc), .rx_clav(rx_clav), .rx_en(rx_en),
    .tx_data(tx_data), .tx_soc(tx_soc), .tx_en(tx_en), .tx_clav(tx_clav),
    .rx_cells(rx_cells), .tx_cells(tx_cells), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int exp_rx = 0, exp_err = 0, mon_err = 0, mon_idx = 0;
  logic [8:0] rx_q[$];     // {soc, data} items offered by the receive PHY
  logic [7:0] exp_q[$];    // bytes that must appear on the transmit side
  logic [7:0] tx_bytes[$]; // bytes observed on the transmit side

  // Receive PHY: presents the next item whenever the block has read enable low.
  always @(negedge clk) begin
    if (rx_en == 1'b0 && rx_q.size() > 0) {rx_soc, rx_data} = rx_q.pop_front();
    rx_clav = (rx_q.size() > 0);
  end

  // Transmit PHY: records bytes and flags soc misplacement or gaps inside a cell.
  always @(negedge clk) begin
    if (!rst_n) mon_idx = 0;
    else if (!tx_en) begin
      if (tx_soc !== (mon_idx == 0)) mon_err++;
      tx_bytes.push_back(tx_data);
      mon_idx = (mon_idx == 52) ? 0 : mon_idx + 1;
    end else if (mon_idx != 0) begin
      mon_err++;
      mon_idx = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // A valid cell: forwarded byte-exact and counted once.
  task automatic add_cell(input bit rnd, input logic [7:0] base);
    logic [7:0] b;
    for (int i = 0; i < 53; i++) begin
      b = rnd ? 8'($urandom) : 8'(base + i);
      rx_q.push_back({(i == 0), b});
      exp_q.push_back(b);
    end
    exp_rx++;
  endtask

  // Bytes without soc where a cell should start: each one is a framing error.
  task automatic add_junk(input int n);
    for (int i = 0; i < n; i++) rx_q.push_back({1'b0, 8'($urandom)});
    exp_err = (exp_err + n > 255) ? 255 : exp_err + n;
  endtask

  // A cell cut short by the next soc: dropped, one framing error.
  task automatic add_partial(input int k);
    for (int i = 0; i < k; i++) rx_q.push_back({(i == 0), 8'($urandom)});
    exp_err = (exp_err + 1 > 255) ? 255 : exp_err + 1;
  endtask

  task automatic drain(input int budget, input bit rnd_clav);
    int n = 0;
    while ((rx_q.size() != 0 || tx_bytes.size() < exp_q.size()) && n < budget) begin
      if (rnd_clav) tx_clav = ($urandom_range(0, 3) != 0);
      tick(1);
      n++;
    end
    tx_clav = 1'b1;
    tick(4);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_nbytes"}, tx_bytes.size(), exp_q.size());
    while (tx_bytes.size() > 0 && exp_q.size() > 0)
      chk({tag, "_byte"}, tx_bytes.pop_front(), exp_q.pop_front());
    tx_bytes.delete();
    exp_q.delete();
    chk({tag, "_rx_cells"}, rx_cells, exp_rx);
    chk({tag, "_tx_cells"}, tx_cells, exp_rx);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
    chk({tag, "_framing"}, mon_err, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rx_en"}, rx_en, 1);
    chk({tag, "_tx_en"}, tx_en, 1);
    chk({tag, "_tx_soc"}, tx_soc, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_rx_cells"}, rx_cells, 0);
    chk({tag, "_tx_cells"}, tx_cells, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    int n;
    tick(3);
    check_reset("reset");
    rst_n = 1'b1;
    tick(2);

    // Single counting-pattern cell
    tx_clav = 1'b1;
    add_cell(1'b0, 8'h00);
    drain(300, 1'b0);
    check_all("single");

    // Transmit blocked: buffer fills at two cells
    tx_clav = 1'b0;
    repeat (3) add_cell(1'b1, 8'h00);
    n = 0;
    while (int'(rx_cells) != 3 - 1 + (exp_rx - 3) && n < 400) begin tick(1); n++; end
    tick(60);
    chk("full_rx_cells", rx_cells, exp_rx - 1);
    chk("full_rx_en", rx_en, 1);
    chk("full_rx_q", rx_q.size(), 53);
    chk("full_tx_cells", tx_cells, exp_rx - 3);
    tx_clav = 1'b1;
    drain(600, 1'b0);
    check_all("full");

    // Two bytes without soc, then a valid cell
    add_junk(2);
    add_cell(1'b1, 8'h00);
    drain(300, 1'b0);
    check_all("nosoc");

    // soc reasserted at index 20
    add_partial(20);
    add_cell(1'b1, 8'h00);
    drain(300, 1'b0);
    check_all("resoc");

    // tx_clav dropped mid-cell must not interrupt the cell
    add_cell(1'b1, 8'h00);
    n = 0;
    while (tx_bytes.size() < 10 && n < 300) begin tick(1); n++; end
    tx_clav = 1'b0;
    tick(100);
    check_all("clavdrop");
    tx_clav = 1'b1;

    // Randomized mix of good cells, junk and truncated cells with random tx_clav
    for (int c = 0; c < 10; c++) begin
      case ($urandom_range(0, 2))
        0: ;
        1: add_junk($urandom_range(1, 3));
        default: add_partial($urandom_range(1, 52));
      endcase
      add_cell(1'b1, 8'h00);
    end
    drain(4000, 1'b1);
    check_all("random");

    // Error counter saturation
    add_junk(300);
    add_cell(1'b1, 8'h00);
    drain(800, 1'b0);
    check_all("saturate");

    // Reset mid-cell with one cell buffered
    tx_clav = 1'b0;
    add_cell(1'b1, 8'h00);
    n = 0;
    while (int'(rx_cells) != exp_rx && n < 300) begin tick(1); n++; end
    chk("prereset_rx_cells", rx_cells, exp_rx);
    for (int i = 0; i < 53; i++) rx_q.push_back({(i == 0), 8'($urandom)});
    n = 0;
    while (rx_q.size() > 23 && n < 300) begin tick(1); n++; end
    rst_n = 1'b0;
    rx_q.delete();
    tick(1);
    check_reset("midreset");
    rst_n = 1'b1;
    exp_rx = 0;
    exp_err = 0;
    exp_q.delete();
    tx_bytes.delete();
    tx_clav = 1'b1;
    tick(200);
    chk("postreset_nbytes", tx_bytes.size(), 0);
    chk("postreset_tx_cells", tx_cells, 0);
    chk("postreset_tx_en", tx_en, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
